// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
// A frame is a header byte, the payload bytes (MSB first), then an XOR check byte.
package uart_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        CHECK
    } state_e;

    localparam logic [3:0] HEADER_TAG = 4'hA;

    function automatic int frame_len(input int data_bytes);
        return data_bytes + 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered last-grant pointer.
// The search starts one past the last granted requester and wraps modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         update_en,
    output logic [N-1:0] grant
);

    localparam int PTR_W = $clog2(N);

    logic [PTR_W-1:0] last_q, last_d;

    // NOTE: every combinational output gets a default before any branch, so no path infers a latch.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        grant  = '0;
        last_d = last_q;
        for (int k = 1; k <= N; k++) begin
            idx = PTR_W'((int'(last_q) + k) % N);
            if (grant == '0 && req[idx]) begin
                grant[idx] = 1'b1;
                if (update_en) begin
                    last_d = idx;
                end
            end
        end
    end

    // Pointer resets to N-1 so requester 0 is searched first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= PTR_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Picks one requester word round-robin and emits it as a byte frame:
// header {A, index}, payload MSB byte first, then the XOR of all preceding bytes.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_BYTES = 3,
    localparam int DATA_W     = DATA_BYTES * 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      byte_valid,
    input  logic                      byte_ready,
    output logic [7:0]                byte_data,
    output logic                      busy,
    output logic [15:0]               frame_count
);

    localparam int CNT_W = $clog2(frame_len(DATA_BYTES));

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   payload_q, payload_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                byte_valid_q, byte_valid_d;
    logic [7:0]          byte_data_q, byte_data_d;
    logic [7:0]          chk_q, chk_d;
    logic [15:0]         frame_count_q, frame_count_d;

    logic [NUM_REQ-1:0]  grant;
    logic                word_xfer;
    logic                byte_xfer;
    logic [DATA_W-1:0]   sel_payload;
    logic [3:0]          sel_idx;
    logic [7:0]          next_byte;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .update_en (word_xfer),
        .grant     (grant)
    );

    assign req_ready   = (state_q == IDLE) ? grant : '0;
    assign word_xfer   = |(req_valid & req_ready);
    assign byte_xfer   = byte_valid_q & byte_ready;
    assign byte_valid  = byte_valid_q;
    assign byte_data   = byte_data_q;
    assign busy        = (state_q != IDLE);
    assign frame_count = frame_count_q;

    // cnt_q is the index of the next payload byte to present.
    assign next_byte = 8'(payload_q >> (8 * (DATA_BYTES - 1 - int'(cnt_q))));

    always_comb begin
        sel_payload = '0;
        sel_idx     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_payload = req_data[i*DATA_W +: DATA_W];
                sel_idx     = 4'(i);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        payload_d     = payload_q;
        cnt_d         = cnt_q;
        byte_valid_d  = byte_valid_q;
        byte_data_d   = byte_data_q;
        chk_d         = chk_q;
        frame_count_d = frame_count_q;
        case (state_q)
            IDLE: if (word_xfer) begin
                payload_d    = sel_payload;
                byte_valid_d = 1'b1;
                byte_data_d  = {HEADER_TAG, sel_idx};
                chk_d        = {HEADER_TAG, sel_idx};
                cnt_d        = '0;
                state_d      = HEADER;
            end
            HEADER: if (byte_xfer) begin
                byte_data_d = next_byte;
                chk_d       = chk_q ^ next_byte;
                cnt_d       = CNT_W'(1);
                state_d     = DATA;
            end
            DATA: if (byte_xfer) begin
                if (cnt_q == CNT_W'(DATA_BYTES)) begin
                    byte_data_d = chk_q;
                    state_d     = CHECK;
                end else begin
                    byte_data_d = next_byte;
                    chk_d       = chk_q ^ next_byte;
                    cnt_d       = cnt_q + CNT_W'(1);
                end
            end
            CHECK: if (byte_xfer) begin
                byte_valid_d  = 1'b0;
                frame_count_d = frame_count_q + 16'd1;
                cnt_d         = '0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: flops use <= so every register samples the pre-edge values of the others.
    // NOTE: the payload buffer is reset too, so nothing from an abandoned frame survives reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            payload_q     <= '0;
            cnt_q         <= '0;
            byte_valid_q  <= 1'b0;
            byte_data_q   <= '0;
            chk_q         <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            payload_q     <= payload_d;
            cnt_q         <= cnt_d;
            byte_valid_q  <= byte_valid_d;
            byte_data_q   <= byte_data_d;
            chk_q         <= chk_d;
            frame_count_q <= frame_count_d;
        end
    end

endmodule
